// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and types for the regfile_sb register file.
package regfile_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam bit WR1_WINS = 1'b1;
  typedef struct packed {
    logic                  en;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } wr_port_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits with reserve-over-clear priority and registered busy count.
// With REGFILE_BYPASS_EN the busy read ports show the post-edge value.
module regfile_scoreboard #(
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_reg,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_reg,
  input  logic [ADDR_W-1:0] rd_a,
  input  logic [ADDR_W-1:0] rd_b,
  output logic              busy_a,
  output logic              busy_b,
  output logic [ADDR_W:0]   busy_count
);
  localparam int N = 1 << ADDR_W;
  logic [N-1:0]    r_busy;
  logic [N-1:0]    w_busy_nxt;
  logic [N-1:0]    w_busy_vis;
  logic [ADDR_W:0] r_cnt;
  logic [ADDR_W:0] w_cnt;
  // reserve is applied last so it wins over a same-cycle load return
  always_comb begin
    w_busy_nxt = r_busy;
    if (clr_en) w_busy_nxt[clr_reg] = 1'b0;
    if (set_en) w_busy_nxt[set_reg] = 1'b1;
    if (ZERO_REG != 0) w_busy_nxt[0] = 1'b0;
  end
  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < N; i++) w_cnt = w_cnt + (ADDR_W+1)'(w_busy_nxt[i]);
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      r_busy <= '0;
      r_cnt  <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      r_cnt  <= w_cnt;
    end
`ifdef REGFILE_BYPASS_EN
  assign w_busy_vis = w_busy_nxt;
`else
  assign w_busy_vis = r_busy;
`endif
  assign busy_a     = reset_n && w_busy_vis[rd_a];
  assign busy_b     = reset_n && w_busy_vis[rd_b];
  assign busy_count = r_cnt;
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: two-write-port register file (W0 ALU, W1 load return) with a load scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data and busy updates to the read ports.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              ctrl_writeEnable0,
  input  logic [ADDR_W-1:0] ctrl_writeReg0,
  input  logic [DATA_W-1:0] data_writeReg0,
  input  logic              ctrl_writeEnable1,
  input  logic [ADDR_W-1:0] ctrl_writeReg1,
  input  logic [DATA_W-1:0] data_writeReg1,
  input  logic              ctrl_reserveEnable,
  input  logic [ADDR_W-1:0] ctrl_reserveReg,
  input  logic [ADDR_W-1:0] ctrl_readRegA,
  input  logic [ADDR_W-1:0] ctrl_readRegB,
  output logic [DATA_W-1:0] data_readRegA,
  output logic [DATA_W-1:0] data_readRegB,
  output logic              busy_readRegA,
  output logic              busy_readRegB,
  output logic [ADDR_W:0]   busy_count
);
  localparam int N = 1 << ADDR_W;
  logic [DATA_W-1:0] r_mem [N];
  logic              w_we0;
  logic              w_we1;
  assign w_we1 = ctrl_writeEnable1 && !(ZERO_REG != 0 && ctrl_writeReg1 == '0);
  assign w_we0 = ctrl_writeEnable0 && !(ZERO_REG != 0 && ctrl_writeReg0 == '0) &&
                 !(WR1_WINS && ctrl_writeEnable1 && ctrl_writeReg1 == ctrl_writeReg0);
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < N; i++) r_mem[i] <= '0;
    end else begin
      if (w_we0) r_mem[ctrl_writeReg0] <= data_writeReg0;
      if (w_we1) r_mem[ctrl_writeReg1] <= data_writeReg1;
    end
  always_comb begin
`ifdef REGFILE_BYPASS_EN
    data_readRegA = (w_we1 && ctrl_writeReg1 == ctrl_readRegA) ? data_writeReg1 :
                    (w_we0 && ctrl_writeReg0 == ctrl_readRegA) ? data_writeReg0 : r_mem[ctrl_readRegA];
    data_readRegB = (w_we1 && ctrl_writeReg1 == ctrl_readRegB) ? data_writeReg1 :
                    (w_we0 && ctrl_writeReg0 == ctrl_readRegB) ? data_writeReg0 : r_mem[ctrl_readRegB];
`else
    data_readRegA = r_mem[ctrl_readRegA];
    data_readRegB = r_mem[ctrl_readRegB];
`endif
    data_readRegA = reset_n ? data_readRegA : '0;
    data_readRegB = reset_n ? data_readRegB : '0;
  end
  regfile_scoreboard #(.ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_sb (
    .clock      (clock),
    .reset_n    (reset_n),
    .set_en     (ctrl_reserveEnable),
    .set_reg    (ctrl_reserveReg),
    .clr_en     (ctrl_writeEnable1),
    .clr_reg    (ctrl_writeReg1),
    .rd_a       (ctrl_readRegA),
    .rd_b       (ctrl_readRegB),
    .busy_a     (busy_readRegA),
    .busy_b     (busy_readRegB),
    .busy_count (busy_count)
  );
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: checks regfile_sb (ZERO_REG=0 and ZERO_REG=1 instances) against a per-register model.
module tb_regfile_sb;
  logic        clock = 1'b0;
  logic        reset_n;
  logic        we0, we1, rsv;
  logic [4:0]  wa0, wa1, rr, ra, rb;
  logic [31:0] d0, d1;
  logic [31:0] rda [2];
  logic [31:0] rdb [2];
  logic        bsa [2];
  logic        bsb [2];
  logic [5:0]  cnt [2];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] m_mem  [2][32];
  logic        m_busy [2][32];

  always #5 clock = ~clock;

  regfile_sb #(.ZERO_REG(0)) u0 (
    .clock(clock), .reset_n(reset_n),
    .ctrl_writeEnable0(we0), .ctrl_writeReg0(wa0), .data_writeReg0(d0),
    .ctrl_writeEnable1(we1), .ctrl_writeReg1(wa1), .data_writeReg1(d1),
    .ctrl_reserveEnable(rsv), .ctrl_reserveReg(rr),
    .ctrl_readRegA(ra), .ctrl_readRegB(rb),
    .data_readRegA(rda[0]), .data_readRegB(rdb[0]),
    .busy_readRegA(bsa[0]), .busy_readRegB(bsb[0]), .busy_count(cnt[0]));

  regfile_sb #(.ZERO_REG(1)) u1 (
    .clock(clock), .reset_n(reset_n),
    .ctrl_writeEnable0(we0), .ctrl_writeReg0(wa0), .data_writeReg0(d0),
    .ctrl_writeEnable1(we1), .ctrl_writeReg1(wa1), .data_writeReg1(d1),
    .ctrl_reserveEnable(rsv), .ctrl_reserveReg(rr),
    .ctrl_readRegA(ra), .ctrl_readRegB(rb),
    .data_readRegA(rda[1]), .data_readRegB(rdb[1]),
    .busy_readRegA(bsa[1]), .busy_readRegB(bsb[1]), .busy_count(cnt[1]));

  // Model: each register applies the rules independently; instance 1 treats r0 as hardwired zero.
  always @(posedge clock or negedge reset_n)
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < 32; r++)
        if (!reset_n) begin
          m_mem[k][r]  = 32'd0;
          m_busy[k][r] = 1'b0;
        end else if (!(k == 1 && r == 0)) begin
          if (we1 && int'(wa1) == r) m_mem[k][r] = d1;
          else if (we0 && int'(wa0) == r) m_mem[k][r] = d0;
          if (rsv && int'(rr) == r) m_busy[k][r] = 1'b1;
          else if (we1 && int'(wa1) == r) m_busy[k][r] = 1'b0;
        end

  function automatic logic [31:0] exp_data(int k, logic [4:0] a);
    if (!reset_n || (k == 1 && a == 5'd0)) return 32'd0;
`ifdef REGFILE_BYPASS_EN
    if (we1 && wa1 == a) return d1;
    if (we0 && wa0 == a) return d0;
`endif
    return m_mem[k][a];
  endfunction

  function automatic logic [31:0] exp_busy(int k, logic [4:0] a);
    if (!reset_n || (k == 1 && a == 5'd0)) return 32'd0;
`ifdef REGFILE_BYPASS_EN
    if (rsv && rr == a) return 32'd1;
    if (we1 && wa1 == a) return 32'd0;
`endif
    return 32'(m_busy[k][a]);
  endfunction

  function automatic logic [31:0] exp_cnt(int k);
    int n = 0;
    for (int r = 0; r < 32; r++) n += int'(m_busy[k][r]);
    return 32'(n);
  endfunction

  task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst%0d t=%0t got=%h want=%h", nm, k, $time, act, exp);
    end
  endtask

  always @(negedge clock)
    for (int k = 0; k < 2; k++) begin
      chk("model_rdA", k, rda[k], exp_data(k, ra));
      chk("model_rdB", k, rdb[k], exp_data(k, rb));
      chk("model_bsA", k, 32'(bsa[k]), exp_busy(k, ra));
      chk("model_bsB", k, 32'(bsb[k]), exp_busy(k, rb));
      chk("model_cnt", k, 32'(cnt[k]), exp_cnt(k));
    end

  task automatic idle();
    we0 = 0; we1 = 0; rsv = 0; wa0 = 0; wa1 = 0; rr = 0; d0 = 0; d1 = 0;
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic go(logic e0, logic [4:0] a0, logic [31:0] v0, logic e1, logic [4:0] a1,
                    logic [31:0] v1, logic e2, logic [4:0] a2);
    we0 = e0; wa0 = a0; d0 = v0; we1 = e1; wa1 = a1; d1 = v1; rsv = e2; rr = a2;
    tick();
    idle();
  endtask

  task automatic peek(logic [4:0] a, logic [4:0] b);
    ra = a; rb = b;
    #1;
  endtask

  initial begin
    reset_n = 0; ra = 0; rb = 0;
    idle();
    tick(); tick();
    for (int k = 0; k < 2; k++) chk("rst_cnt", k, 32'(cnt[k]), 32'd0);
    reset_n = 1;
    go(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    peek(5, 0);
    for (int k = 0; k < 2; k++) chk("w0_r5", k, rda[k], 32'hDEADBEEF);
    go(1, 7, 32'h1111, 1, 7, 32'h2222, 0, 0);
    peek(7, 0);
    for (int k = 0; k < 2; k++) chk("w1_wins", k, rda[k], 32'h2222);
    go(1, 3, 32'h33, 1, 4, 32'h44, 0, 0);
    peek(3, 4);
    for (int k = 0; k < 2; k++) begin
      chk("both_r3", k, rda[k], 32'h33);
      chk("both_r4", k, rdb[k], 32'h44);
    end
    go(0, 0, 0, 0, 0, 0, 1, 9);
    peek(9, 0);
    for (int k = 0; k < 2; k++) begin
      chk("rsv_busy", k, 32'(bsa[k]), 32'd1);
      chk("rsv_cnt", k, 32'(cnt[k]), 32'd1);
    end
    go(0, 0, 0, 1, 9, 32'h55, 0, 0);
    peek(9, 0);
    for (int k = 0; k < 2; k++) begin
      chk("clr_busy", k, 32'(bsa[k]), 32'd0);
      chk("clr_data", k, rda[k], 32'h55);
      chk("clr_cnt", k, 32'(cnt[k]), 32'd0);
    end
    go(0, 0, 0, 1, 9, 32'h66, 1, 9);
    peek(9, 0);
    for (int k = 0; k < 2; k++) chk("rsv_over_clr", k, 32'(bsa[k]), 32'd1);
    go(1, 0, 32'hFFFFFFFF, 1, 0, 32'hFFFFFFFF, 1, 0);
    peek(0, 0);
    chk("r0_plain", 0, rda[0], 32'hFFFFFFFF);
    chk("r0_plain_cnt", 0, 32'(cnt[0]), 32'd2);
    chk("r0_zero", 1, rda[1], 32'd0);
    chk("r0_zero_busy", 1, 32'(bsa[1]), 32'd0);
    chk("r0_zero_cnt", 1, 32'(cnt[1]), 32'd1);
    go(1, 12, 32'h1200, 0, 0, 0, 1, 12);
    we1 = 1; wa1 = 12; d1 = 32'hABCD;
    peek(0, 12);
    for (int k = 0; k < 2; k++) begin
`ifdef REGFILE_BYPASS_EN
      chk("byp_data", k, rdb[k], 32'hABCD);
      chk("byp_busy", k, 32'(bsb[k]), 32'd0);
`else
      chk("nobyp_data", k, rdb[k], 32'h1200);
      chk("nobyp_busy", k, 32'(bsb[k]), 32'd1);
`endif
    end
    tick();
    idle();
    peek(0, 12);
    for (int k = 0; k < 2; k++) begin
      chk("after_data", k, rdb[k], 32'hABCD);
      chk("after_busy", k, 32'(bsb[k]), 32'd0);
    end
    peek(7, 9);
    reset_n = 0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("mid_rst_rd", k, rda[k], 32'd0);
      chk("mid_rst_bs", k, 32'(bsb[k]), 32'd0);
      chk("mid_rst_cnt", k, 32'(cnt[k]), 32'd0);
    end
    tick();
    reset_n = 1;
    go(0, 0, 0, 1, 9, 32'h77, 0, 0);
    peek(9, 0);
    for (int k = 0; k < 2; k++) begin
      chk("post_rst_data", k, rda[k], 32'h77);
      chk("post_rst_cnt", k, 32'(cnt[k]), 32'd0);
    end
    for (int r = 0; r < 32; r++) go(0, 0, 0, 0, 0, 0, 1, 5'(r));
    chk("fill_cnt", 0, 32'(cnt[0]), 32'd32);
    chk("fill_cnt", 1, 32'(cnt[1]), 32'd31);
    for (int r = 0; r < 32; r++) go(0, 0, 0, 1, 5'(r), 32'(r), 0, 0);
    for (int k = 0; k < 2; k++) chk("drain_cnt", k, 32'(cnt[k]), 32'd0);
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
